dbg_run_ctrl: RTL and testbench
===============================

# dbg_run_ctrl

Run/halt/single-step controller for the NPC core's debug path. Sits between the host-side debug command interface and the core's commit stage. Gates instruction issue through a stall line, counts retired instructions, halts on ebreak, invalid instruction, hardware PC breakpoint or step exhaustion, and produces the per-commit `done` strobe and retired PC consumed by the DPI debug reporter.

## Interface
Parameters:
- NBKPT, 2, number of hardware PC breakpoints (1..8)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command strobe
- cmd_op  in  2  0 RUN, 1 HALT, 2 STEP, 3 CLRCNT
- cmd_arg  in  32  step count for STEP
- bkpt_wen  in  1  breakpoint register write
- bkpt_idx  in  $clog2(NBKPT) (min 1)  breakpoint slot
- bkpt_addr  in  32  breakpoint PC
- bkpt_en  in  1  slot enable
- commit_valid  in  1  core retires an instruction this cycle
- commit_pc  in  32  PC of retiring instruction
- brk  in  1  retiring instruction is ebreak (qualified by commit_valid)
- ivd  in  1  retiring instruction is invalid (qualified by commit_valid)
- core_stall  out  1  core must not retire further instructions
- halted  out  1  controller in HALTED
- halt_cause  out  3  0 reset, 1 host, 2 step, 3 ebreak, 4 invalid, 5 breakpoint
- inst_count  out  CNT_W  retired-instruction count
- done  out  1  one-cycle pulse per accepted commit
- retire_pc  out  32  PC of last accepted commit

## Operation
- States: HALTED, RUNNING, STEPPING. Reset enters HALTED, cause 0.
- HALTED: RUN -> RUNNING; STEP -> STEPPING with step_left = cmd_arg (0 treated as 1); HALT ignored.
- RUNNING/STEPPING: HALT -> HALTED, cause 1; RUN/STEP ignored.
- CLRCNT is accepted in every state and does not change state.
- Commit accepted when commit_valid and state != HALTED. Effects: inst_count += 1 (wraps modulo 2^CNT_W), retire_pc <= commit_pc, done pulses, step_left -= 1 in STEPPING.
- Halt on accepted commit. Priority: ivd (4) > brk (3) > breakpoint match (5) > step_left reaching 0 (2). The halting instruction is itself counted and reported; halting is always after retirement.
- Breakpoint match: any enabled slot with bkpt_addr == commit_pc. Slots are writable in any state. A slot written in the same cycle as a matching commit uses the old value.
- Simultaneous events in one cycle:
  - HALT command and a halting commit: the commit's cause wins.
  - CLRCNT and a commit: clear wins; inst_count = 0.
- commit_valid while HALTED is an illegal core behaviour. It is ignored: no count, no done.

## Timing
- All outputs are registered. Reset values: core_stall 1, halted 1, halt_cause 0, inst_count 0, done 0, retire_pc 0, all breakpoint slots disabled.
- core_stall = (state == HALTED). A command in cycle t takes effect at t+1: a RUN at t gives core_stall low at t+1.
- An accepted commit at t gives done, retire_pc and inst_count at t+1.
- A halting commit at t gives halted, core_stall and halt_cause at t+1.
- A commit in the same cycle as a host HALT is accepted and counted. The core must honour core_stall combinationally on its retire enable, so no commit is accepted after the halted cycle.
- Asynchronous reset mid-run aborts immediately. Pending step count and breakpoints are discarded.

## Structure
- Package dbg_pkg holds:
  - cmd_op enum (RUN/HALT/STEP/CLRCNT)
  - halt_cause enum (3-bit codes above)
  - FSM state enum
  - CNT_W default constant
- Sub-module dbg_bkpt_match holds the NBKPT address/enable registers and the parallel comparator. It outputs a single registered-input-free match bit.
- The top level holds the FSM, step counter, instruction counter and output registers.

## Test plan
- Reset release: all outputs at reset values; core_stall=1, halt_cause=0, inst_count=0.
- STEP arg=3, commits on 3 consecutive cycles:
  - three done pulses, inst_count=3;
  - halted at the cycle after the 3rd commit, halt_cause=2.
- RUN with breakpoint slot0=0x80000010 enabled, commits at 0x80000000..0x80000010 step 4:
  - halt after 0x80000010, retire_pc=0x80000010, inst_count=5, halt_cause=5.
- RUN, commit pc 0x80000008 with brk=1 and ivd=1 together: halt_cause=4, inst_count incremented.
- RUN, HALT cmd same cycle as a commit with brk=1: halt_cause=3; CLRCNT with a commit gives inst_count=0.
- CNT_W=4, 17 commits in RUN: inst_count=1 (wrap). Assert reset_n low mid-run: outputs reset asynchronously and breakpoints are cleared.

Source files
------------

// File: rtl/dbg_run_ctrl_pkg.sv
`default_nettype none
// ====================================================================
// dbg_pkg: shared types for the debug run/halt/step controller
// Rev 1.0
// ====================================================================
package dbg_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int NBKPT_DEF = 2;

  typedef enum logic [1:0] {
    OP_RUN    = 2'd0,
    OP_HALT   = 2'd1,
    OP_STEP   = 2'd2,
    OP_CLRCNT = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_RESET   = 3'd0,
    CAUSE_HOST    = 3'd1,
    CAUSE_STEP    = 3'd2,
    CAUSE_EBREAK  = 3'd3,
    CAUSE_INVALID = 3'd4,
    CAUSE_BKPT    = 3'd5
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  // A single breakpoint slot still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_run_ctrl_if.sv
`default_nettype none
// ====================================================================
// dbg_run_ctrl_if: host command, breakpoint, commit and status bundle
// Rev 1.0
// ====================================================================
interface dbg_run_ctrl_if import dbg_pkg::*; #(
  parameter int NBKPT = NBKPT_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  localparam int IDX_W = idx_w(NBKPT);

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_arg;
  logic             bkpt_wen;
  logic [IDX_W-1:0] bkpt_idx;
  logic [31:0]      bkpt_addr;
  logic             bkpt_en;
  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic             brk;
  logic             ivd;
  logic             core_stall;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] inst_count;
  logic             done;
  logic [31:0]      retire_pc;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    output bkpt_wen, bkpt_idx, bkpt_addr, bkpt_en,
    output commit_valid, commit_pc, brk, ivd,
    input  core_stall, halted, halt_cause, inst_count, done, retire_pc
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    input  bkpt_wen, bkpt_idx, bkpt_addr, bkpt_en,
    input  commit_valid, commit_pc, brk, ivd,
    output core_stall, halted, halt_cause, inst_count, done, retire_pc
  );

endinterface
`default_nettype wire

// File: rtl/dbg_run_ctrl_bkpt_match.sv
`default_nettype none
// ====================================================================
// dbg_bkpt_match: hardware PC breakpoint slots and parallel comparator
// Rev 1.0
// ====================================================================
module dbg_bkpt_match import dbg_pkg::*; #(
  parameter int NBKPT = NBKPT_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wen,
  input  logic [idx_w(NBKPT)-1:0]   idx,
  input  logic [31:0]               addr,
  input  logic                      en,
  input  logic [31:0]               pc,
  output logic                      match
);

  localparam int IDX_W = idx_w(NBKPT);

  logic [NBKPT-1:0] w_hit;

  generate
    for (genvar g = 0; g < NBKPT; g++) begin : g_slot
      logic [31:0] r_addr;
      logic        r_en;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_addr <= '0;
          r_en   <= 1'b0;
        end else if (wen && (idx == IDX_W'(g))) begin
          r_addr <= addr;
          r_en   <= en;
        end
      end

      // Compare against the stored value so a same-cycle write is not seen.
      assign w_hit[g] = r_en && (r_addr == pc);
    end
  endgenerate

  assign match = |w_hit;

endmodule
`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// ====================================================================
// dbg_run_ctrl: run/halt/single-step controller on the core commit path
// Rev 1.0
// ====================================================================
module dbg_run_ctrl import dbg_pkg::*; #(
  parameter int NBKPT = NBKPT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  dbg_run_ctrl_if.slave dbg
);

  state_e      r_state;
  logic [31:0] r_step_left;

  logic        w_bkpt_hit;
  logic        w_accept;
  logic        w_host_halt;
  logic        w_clr;
  logic        w_last_step;
  logic        w_commit_halt;
  halt_cause_e w_commit_cause;

  dbg_bkpt_match #(.NBKPT(NBKPT)) u_bkpt (
    .clk     (clk),
    .reset_n (reset_n),
    .wen     (dbg.bkpt_wen),
    .idx     (dbg.bkpt_idx),
    .addr    (dbg.bkpt_addr),
    .en      (dbg.bkpt_en),
    .pc      (dbg.commit_pc),
    .match   (w_bkpt_hit)
  );

  assign w_accept    = dbg.commit_valid && (r_state != ST_HALTED);
  assign w_host_halt = dbg.cmd_valid && (dbg.cmd_op == OP_HALT);
  assign w_clr       = dbg.cmd_valid && (dbg.cmd_op == OP_CLRCNT);
  assign w_last_step = (r_state == ST_STEPPING) && (r_step_left == 32'd1);

  always_comb begin
    w_commit_halt  = 1'b1;
    w_commit_cause = CAUSE_STEP;
    if (dbg.ivd) begin
      w_commit_cause = CAUSE_INVALID;
    end else if (dbg.brk) begin
      w_commit_cause = CAUSE_EBREAK;
    end else if (w_bkpt_hit) begin
      w_commit_cause = CAUSE_BKPT;
    end else if (w_last_step) begin
      w_commit_cause = CAUSE_STEP;
    end else begin
      w_commit_halt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_HALTED;
      r_step_left     <= '0;
      dbg.core_stall  <= 1'b1;
      dbg.halted      <= 1'b1;
      dbg.halt_cause  <= CAUSE_RESET;
      dbg.inst_count  <= '0;
      dbg.done        <= 1'b0;
      dbg.retire_pc   <= '0;
    end else begin
      dbg.done <= w_accept;

      if (w_accept) begin
        dbg.retire_pc <= dbg.commit_pc;
        if (r_state == ST_STEPPING) begin
          r_step_left <= r_step_left - 32'd1;
        end
      end

      // A clear issued alongside a commit leaves the counter at zero.
      if (w_clr) begin
        dbg.inst_count <= '0;
      end else if (w_accept) begin
        dbg.inst_count <= dbg.inst_count + CNT_W'(1);
      end

      case (r_state)
        ST_HALTED: begin
          if (dbg.cmd_valid && (dbg.cmd_op == OP_RUN)) begin
            r_state        <= ST_RUNNING;
            dbg.core_stall <= 1'b0;
            dbg.halted     <= 1'b0;
          end else if (dbg.cmd_valid && (dbg.cmd_op == OP_STEP)) begin
            r_state        <= ST_STEPPING;
            r_step_left    <= (dbg.cmd_arg == 32'd0) ? 32'd1 : dbg.cmd_arg;
            dbg.core_stall <= 1'b0;
            dbg.halted     <= 1'b0;
          end
        end
        ST_RUNNING, ST_STEPPING: begin
          if (w_accept && w_commit_halt) begin
            r_state        <= ST_HALTED;
            dbg.core_stall <= 1'b1;
            dbg.halted     <= 1'b1;
            dbg.halt_cause <= w_commit_cause;
          end else if (w_host_halt) begin
            r_state        <= ST_HALTED;
            dbg.core_stall <= 1'b1;
            dbg.halted     <= 1'b1;
            dbg.halt_cause <= CAUSE_HOST;
          end
        end
        default: begin
          r_state        <= ST_HALTED;
          dbg.core_stall <= 1'b1;
          dbg.halted     <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbg_run_ctrl.sv
`default_nettype none
// ====================================================================
// tb_dbg_run_ctrl: scoreboard bench for the debug run controller
// Rev 1.0
// ====================================================================
module tb_dbg_run_ctrl;

  localparam int CW = 4;
  localparam logic [1:0] OP_RUN = 2'd0, OP_HALT = 2'd1, OP_STEP = 2'd2, OP_CLR = 2'd3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dbg_run_ctrl_if #(.NBKPT(2), .CNT_W(CW)) bus ();
  dbg_run_ctrl #(.NBKPT(2), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dbg     (bus)
  );

  typedef struct packed {
    logic [31:0]   pc;
    logic [CW-1:0] cnt;
    logic          halted;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] halt_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       prev_halted = 1'b1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endfunction

  // Monitor: every done pulse and every halt entry is matched to the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: retire_pc 0x%0h with no commit expected", bus.retire_pc);
        end else begin
          check("retire_pc", bus.retire_pc, exp_q[0].pc);
          check("inst_count", 32'(bus.inst_count), 32'(exp_q[0].cnt));
          check("halted_after_commit", 32'(bus.halted), 32'(exp_q[0].halted));
          exp_q.delete(0);
        end
      end
      if (bus.halted && !prev_halted) begin
        if (halt_q.size() == 0) begin
          n_checks++;
          $display("FAIL halt_unexpected: cause %0d with no halt expected", bus.halt_cause);
        end else begin
          check("halt_cause", 32'(bus.halt_cause), 32'(halt_q[0]));
          check("core_stall_on_halt", 32'(bus.core_stall), 32'd1);
          halt_q.delete(0);
        end
      end
    end
    prev_halted <= bus.halted;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.cmd_valid    = 1'b0;
    bus.commit_valid = 1'b0;
    bus.brk          = 1'b0;
    bus.ivd          = 1'b0;
    bus.bkpt_wen     = 1'b0;
  endtask

  task automatic host(input logic [1:0] op, input logic [31:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
  endtask

  task automatic bkpt(input logic idx, input logic [31:0] a, input logic en);
    bus.bkpt_wen  = 1'b1;
    bus.bkpt_idx  = idx;
    bus.bkpt_addr = a;
    bus.bkpt_en   = en;
  endtask

  task automatic commit(input logic [31:0] pc, input logic b, input logic i,
                        input logic [CW-1:0] cnt, input logic h);
    exp_t e;
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.brk          = b;
    bus.ivd          = i;
    e.pc = pc; e.cnt = cnt; e.halted = h;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_stall"}, 32'(bus.core_stall), 32'd1);
    check({tag, "_halted"}, 32'(bus.halted), 32'd1);
    check({tag, "_halt_cause"}, 32'(bus.halt_cause), 32'd0);
    check({tag, "_inst_count"}, 32'(bus.inst_count), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_retire_pc"}, bus.retire_pc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = '0;
    bus.bkpt_wen = 1'b0; bus.bkpt_idx = '0; bus.bkpt_addr = '0; bus.bkpt_en = 1'b0;
    bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.brk = 1'b0; bus.ivd = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_reset_values("reset");

    // STEP 3: three commits, halt after the third with cause step.
    host(OP_STEP, 32'd3); tick();
    commit(32'h100, 0, 0, 4'd1, 0); tick();
    commit(32'h104, 0, 0, 4'd2, 0); tick();
    commit(32'h108, 0, 0, 4'd3, 1); halt_q.push_back(3'd2); tick();
    tick();
    check("done_idle", 32'(bus.done), 32'd0);

    // STEP 0 behaves as STEP 1.
    host(OP_STEP, 32'd0); tick();
    commit(32'h10c, 0, 0, 4'd4, 1); halt_q.push_back(3'd2); tick();
    tick();

    // Clear while halted, arm slot 0, run into the breakpoint.
    host(OP_CLR, 32'd0); bkpt(1'b0, 32'h8000_0010, 1'b1); tick();
    check("clr_halted", 32'(bus.inst_count), 32'd0);
    host(OP_RUN, 32'd0); tick();
    commit(32'h8000_0000, 0, 0, 4'd1, 0); tick();
    commit(32'h8000_0004, 0, 0, 4'd2, 0); tick();
    commit(32'h8000_0008, 0, 0, 4'd3, 0); tick();
    commit(32'h8000_000c, 0, 0, 4'd4, 0); tick();
    commit(32'h8000_0010, 0, 0, 4'd5, 1); halt_q.push_back(3'd5); tick();
    tick();

    // Invalid outranks ebreak.
    host(OP_RUN, 32'd0); tick();
    commit(32'h8000_0008, 1, 1, 4'd6, 1); halt_q.push_back(3'd4); tick();
    tick();

    // Host HALT together with an ebreak commit: ebreak wins.
    host(OP_RUN, 32'd0); tick();
    host(OP_HALT, 32'd0); commit(32'h8000_0020, 1, 0, 4'd7, 1); halt_q.push_back(3'd3); tick();
    tick();

    // Plain host halt.
    host(OP_RUN, 32'd0); tick();
    commit(32'h200, 0, 0, 4'd8, 0); tick();
    host(OP_HALT, 32'd0); halt_q.push_back(3'd1); tick();
    tick();

    // Commit while halted is ignored.
    bus.commit_valid = 1'b1; bus.commit_pc = 32'h999; tick();
    tick();
    check("halted_commit_count", 32'(bus.inst_count), 32'd8);
    check("halted_commit_pc", bus.retire_pc, 32'h200);

    // CLRCNT with a commit, then a same-cycle breakpoint write.
    host(OP_RUN, 32'd0); tick();
    host(OP_CLR, 32'd0); commit(32'h300, 0, 0, 4'd0, 0); tick();
    commit(32'h304, 0, 0, 4'd1, 0); tick();
    bkpt(1'b1, 32'h400, 1'b1); commit(32'h400, 0, 0, 4'd2, 0); tick();
    commit(32'h400, 0, 0, 4'd3, 1); halt_q.push_back(3'd5); tick();
    tick();

    // 17 commits on a 4-bit counter wrap to 1.
    host(OP_CLR, 32'd0); tick();
    host(OP_RUN, 32'd0); tick();
    for (int i = 0; i < 17; i++) begin
      commit(32'h1000 + 32'(i * 4), 0, 0, CW'(i + 1), 0);
      tick();
    end
    tick();
    tick();
    check("wrap_count", 32'(bus.inst_count), 32'd1);
    check("wrap_running", 32'(bus.core_stall), 32'd0);

    // Asynchronous reset mid-run, then breakpoints must be gone.
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick(); tick();
    reset_n = 1'b1;
    host(OP_RUN, 32'd0); tick();
    commit(32'h8000_0010, 0, 0, 4'd1, 0); tick();
    commit(32'h400, 0, 0, 4'd2, 0); tick();
    host(OP_HALT, 32'd0); halt_q.push_back(3'd1); tick();
    tick();
    tick();

    check("commit_queue_drained", 32'(exp_q.size()), 32'd0);
    check("halt_queue_drained", 32'(halt_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
